// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - FWFT FIFO for ALU result/overflow pairs with overflow status
// Buffers {overflow, result} entries behind valid/ready handshakes and tracks overflow status.

module alu_result_fifo #(
   parameter int DATA_W    = 4,
   parameter int DEPTH     = 4,
   parameter int OVF_CNT_W = 4,
   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W    = PTR_W + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_result,
   input  logic                 in_overflow,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_result,
   output logic                 out_overflow,
   output logic [CNT_W-1:0]     count,
   output logic                 ovf_sticky,
   output logic [OVF_CNT_W-1:0] ovf_cnt,
   input  logic                 clr_status
);

   logic [DATA_W:0]        mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   sticky_q, sticky_d;
   logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
   logic                   push, pop;

   // Handshake qualifiers depend only on registered occupancy.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_result   = out_valid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
   assign out_overflow = out_valid ? mem_q[rd_ptr_q][DATA_W]     : 1'b0;
   assign count        = count_q;
   assign ovf_sticky   = sticky_q;
   assign ovf_cnt      = ovf_cnt_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      sticky_d  = sticky_q;
      ovf_cnt_d = ovf_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      // An overflowed push outranks a simultaneous clear: it restarts the count at one.
      if (push && in_overflow) begin
         sticky_d = 1'b1;
         if (clr_status)          ovf_cnt_d = OVF_CNT_W'(1);
         else if (~&ovf_cnt_q)    ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
      end else if (clr_status) begin
         sticky_d  = 1'b0;
         ovf_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         sticky_q  <= 1'b0;
         ovf_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         sticky_q  <= sticky_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_overflow, in_result};
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - self-checking bench for alu_result_fifo
// Queue-based reference model, compared on every falling edge.

module tb_alu_result_fifo;

   localparam int DEPTH   = 4;
   localparam int OVF_MAX = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_result = 4'h0;
   logic       in_overflow = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_result;
   logic       out_overflow;
   logic [2:0] count;
   logic       ovf_sticky;
   logic [3:0] ovf_cnt;
   logic       clr_status = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   logic [4:0] mq[$];
   logic       m_sticky = 1'b0;
   int         m_cnt = 0;

   alu_result_fifo dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_overflow(in_overflow),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_overflow(out_overflow),
      .count(count), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt),
      .clr_status(clr_status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_sticky = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_clock();
      bit push, pop;
      if (!rst_n) begin
         model_reset();
         return;
      end
      push = in_valid && (mq.size() < DEPTH);
      pop  = out_ready && (mq.size() > 0);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({in_overflow, in_result});
      if (push && in_overflow) begin
         m_sticky = 1'b1;
         if (clr_status)          m_cnt = 1;
         else if (m_cnt < OVF_MAX) m_cnt = m_cnt + 1;
      end else if (clr_status) begin
         m_sticky = 1'b0;
         m_cnt = 0;
      end
   endtask

   task automatic compare_all();
      int n;
      n = mq.size();
      chk("count",        32'(count),        32'(n));
      chk("out_valid",    32'(out_valid),    32'(n != 0));
      chk("in_ready",     32'(in_ready),     32'(n != DEPTH));
      chk("out_result",   32'(out_result),   (n != 0) ? 32'(mq[0][3:0]) : 32'h0);
      chk("out_overflow", 32'(out_overflow), (n != 0) ? 32'(mq[0][4])   : 32'h0);
      chk("ovf_sticky",   32'(ovf_sticky),   32'(m_sticky));
      chk("ovf_cnt",      32'(ovf_cnt),      32'(m_cnt));
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int popped, guard, pushed;

      // Reset state
      step();
      step();
      chk("reset_in_ready", 32'(in_ready), 32'h1);
      rst_n = 1'b1;

      // Single push of 3, visible next cycle
      in_valid = 1'b1; in_result = 4'h3; in_overflow = 1'b0;
      step();
      chk("first_push_result", 32'(out_result), 32'h3);
      chk("first_push_count",  32'(count),      32'h1);
      in_valid = 1'b0;
      step();

      // Asynchronous reset in the middle of a cycle
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid",  32'(out_valid),  32'h0);
      chk("async_rst_result", 32'(out_result), 32'h0);
      chk("async_rst_count",  32'(count),      32'h0);
      chk("async_rst_ready",  32'(in_ready),   32'h1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Fill with 1..4, then offer F while full
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_result = 4'(i);
         step();
      end
      in_result = 4'hF;
      step();
      step();
      chk("full_in_ready", 32'(in_ready), 32'h0);
      chk("full_count",    32'(count),    32'h4);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_order", 32'(out_result), 32'(i));
         step();
      end
      chk("drained_empty", 32'(out_valid), 32'h0);
      out_ready = 1'b0;

      // Full with simultaneous push and pop: only the pop happens
      for (int i = 5; i <= 8; i++) begin
         in_valid = 1'b1; in_result = 4'(i);
         step();
      end
      in_result = 4'h9; out_ready = 1'b1;
      step();
      chk("full_pushpop_count", 32'(count), 32'h3);
      out_ready = 1'b0;
      step();
      chk("next_cycle_accept", 32'(count), 32'h4);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      step();
      in_valid = 1'b1; in_result = 4'hA;
      step();
      chk("mid_pushpop_count", 32'(count), 32'h2);
      in_valid = 1'b0;
      while (out_valid) step();

      // Wrap: values 0..9 with random consumer pressure
      popped = 0; pushed = 0; guard = 0;
      while (popped < 10 && guard < 300) begin
         in_valid  = (pushed < 10);
         in_result = 4'(pushed);
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            chk("wrap_order", 32'(out_result), 32'(popped));
            popped++;
         end
         if (in_valid && in_ready) pushed++;
         step();
         guard++;
      end
      chk("wrap_done", 32'(popped), 32'd10);
      in_valid = 1'b0; out_ready = 1'b0;

      // Overflow status saturation and clearing
      out_ready = 1'b1; in_valid = 1'b1; in_overflow = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_result = 4'(i);
         step();
      end
      chk("ovf_saturated", 32'(ovf_cnt),    32'hF);
      chk("ovf_sticky_set", 32'(ovf_sticky), 32'h1);
      in_valid = 1'b0; in_overflow = 1'b0;
      step();
      clr_status = 1'b1;
      step();
      chk("clr_cnt",    32'(ovf_cnt),    32'h0);
      chk("clr_sticky", 32'(ovf_sticky), 32'h0);
      in_valid = 1'b1; in_overflow = 1'b1; in_result = 4'h7;
      step();
      chk("clr_push_cnt",    32'(ovf_cnt),    32'h1);
      chk("clr_push_sticky", 32'(ovf_sticky), 32'h1);
      clr_status = 1'b0; in_valid = 1'b0; in_overflow = 1'b0;
      step();
      step();

      // Pop requests while empty must not disturb anything
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("empty_pop_count", 32'(count), 32'h0);
      in_valid = 1'b1; in_result = 4'hC;
      step();
      chk("empty_then_push", 32'(out_result), 32'hC);
      in_valid = 1'b0;
      step();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         in_result   = 4'($urandom);
         in_overflow = 1'($urandom_range(0, 1));
         out_ready   = 1'($urandom_range(0, 1));
         clr_status  = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
